// File: rtl/ram_wb_b3_gen.sv
// ram_wb_b3_gen: Wishbone B3 on-chip RAM slave with a parametrised data width.
//   Byte-enable writes, registered synchronous read with write-to-read bypass,
//   classic, constant and incrementing (linear / wrap-4/8/16) bursts, and an
//   optional read-only mode where writes answer with wb_err_o.
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, asynchronous active-low reset
//   wb_adr_i [aw]              byte address (top nibble ignored)
//   wb_dat_i [dw], wb_sel_i    write data and per-byte selects
//   wb_we_i, wb_bte_i, wb_cti_i, wb_cyc_i, wb_stb_i   bus request
//   wb_ack_o, wb_err_o, wb_rty_o (tied 0), wb_dat_o [dw] registered read data
// memory_file names the hex image loaded into this instance by the memory
// initialisation flow; the RTL itself never preloads contents.
module ram_wb_b3_gen #(
  parameter int          dw             = 32,
  parameter int          aw             = 32,
  parameter              memory_file    = "",
  parameter logic [31:0] mem_size_bytes = 32'h0000_8000,
  parameter int          mem_adr_width  = 15,
  parameter bit          read_only      = 1'b0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_bte_i,
  input  logic [2:0]      wb_cti_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic [dw-1:0]   wb_dat_o
);

  localparam int nb    = dw / 8;
  localparam int bw    = $clog2(nb);
  localparam int wiw   = mem_adr_width - bw;
  localparam int words = int'(mem_size_bytes) / nb;
  localparam int iw    = $clog2(words);

  typedef enum logic [1:0] {IDLE = 2'd0, CLASSIC = 2'd1, BURST = 2'd2} state_t;

  logic [dw-1:0]  mem_r [0:words-1];
  state_t         state_r, state_nxt_s;
  logic           ack_r, ack_nxt_s, err_r, err_nxt_s;
  logic [wiw-1:0] cnt_r, cnt_nxt_s, nxt_idx_s, rd_idx_s, wi_s;
  logic           cs_s, upper_s, addr_err_s, ro_err_s, beat_bad_s, burst_cti_s;
  logic           rd_en_s, wr_en_s, bypass_s;
  logic [dw-1:0]  merged_s;
  logic           unused_s;

  // Next counter value for a burst beat; wrap modes only touch the low bits.
  function automatic logic [wiw-1:0] advance(input logic [wiw-1:0] cnt,
                                             input logic [2:0] cti,
                                             input logic [1:0] bte);
    logic [wiw-1:0] r;
    r = cnt;
    if (cti == 3'b010) begin
      case (bte)
        2'b00:   r = (32'(cnt) == 32'(words) - 32'd1) ? '0 : cnt + {{(wiw-1){1'b0}}, 1'b1};
        2'b01:   r[1:0] = cnt[1:0] + 2'd1;
        2'b10:   r[2:0] = cnt[2:0] + 3'd1;
        2'b11:   r[3:0] = cnt[3:0] + 4'd1;
        default: r = cnt;
      endcase
    end else begin
      r = cnt;
    end
    return r;
  endfunction

  assign cs_s        = wb_cyc_i & wb_stb_i;
  assign wi_s        = wb_adr_i[mem_adr_width-1:bw];
  assign upper_s     = |wb_adr_i[aw-5:mem_adr_width];
  assign addr_err_s  = cs_s & (upper_s | ({{(32-wiw){1'b0}}, wi_s} >= 32'(words)));
  assign ro_err_s    = read_only & wb_we_i;
  assign burst_cti_s = (wb_cti_i == 3'b001) | (wb_cti_i == 3'b010);
  // A burst beat whose address is not the one we prefetched gets an error instead of an ack.
  assign beat_bad_s  = (state_r == BURST) & cs_s & ((wi_s != cnt_r) | addr_err_s | ro_err_s);
  assign nxt_idx_s   = advance(cnt_r, wb_cti_i, wb_bte_i);
  assign wb_ack_o    = ack_r & cs_s & ~beat_bad_s;
  assign wb_err_o    = err_r & cs_s;
  assign wb_rty_o    = 1'b0;
  assign unused_s    = ^{wb_adr_i, rd_idx_s};

  // Current word with the selected bytes of the write data merged in (bypass source).
  always_comb begin
    merged_s = mem_r[cnt_r[iw-1:0]];
    for (int k = 0; k < nb; k++) begin
      if (wb_sel_i[k]) begin
        merged_s[8*k +: 8] = wb_dat_i[8*k +: 8];
      end else begin
        merged_s[8*k +: 8] = mem_r[cnt_r[iw-1:0]][8*k +: 8];
      end
    end
  end

  // Next-state, handshake and memory-access decisions.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    cnt_nxt_s   = cnt_r;
    rd_en_s     = 1'b0;
    rd_idx_s    = cnt_r;
    wr_en_s     = 1'b0;
    bypass_s    = 1'b0;
    if (!wb_cyc_i) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // While err_r is high the cycle is the error pulse itself, not a new request.
          if (wb_stb_i && !err_r) begin
            if (addr_err_s || ro_err_s) begin
              err_nxt_s = 1'b1;
            end else begin
              cnt_nxt_s   = wi_s;
              rd_en_s     = 1'b1;
              rd_idx_s    = wi_s;
              ack_nxt_s   = 1'b1;
              state_nxt_s = burst_cti_s ? BURST : CLASSIC;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CLASSIC: begin
          state_nxt_s = IDLE;
          wr_en_s     = wb_stb_i & wb_we_i & ~read_only;
        end
        BURST: begin
          if (!wb_stb_i) begin
            ack_nxt_s = ack_r;
          end else if (beat_bad_s) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            wr_en_s = wb_we_i;
            if (wb_cti_i == 3'b111) begin
              state_nxt_s = IDLE;
            end else begin
              cnt_nxt_s = nxt_idx_s;
              rd_en_s   = 1'b1;
              rd_idx_s  = nxt_idx_s;
              ack_nxt_s = 1'b1;
              bypass_s  = wb_we_i & (nxt_idx_s == cnt_r);
            end
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Control registers and registered read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r  <= IDLE;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      cnt_r    <= '0;
      wb_dat_o <= '0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (rd_en_s) begin
        wb_dat_o <= bypass_s ? merged_s : mem_r[rd_idx_s[iw-1:0]];
      end
    end
  end

  // Byte-enable memory write; contents are not affected by reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_s) begin
      for (int k = 0; k < nb; k++) begin
        if (wb_sel_i[k]) begin
          mem_r[cnt_r[iw-1:0]][8*k +: 8] <= wb_dat_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_wb_b3_gen.sv
// Directed bench for ram_wb_b3_gen: a 32-bit instance, a 64-bit instance with a
// 256-byte memory and a read-only instance share one bus; tsel picks the target.
module tb_ram_wb_b3_gen;
  logic        clk = 1'b0;
  logic        rst_n, cyc, stb, we;
  logic [31:0] adr;
  logic [63:0] dat;
  logic [7:0]  sel;
  logic [1:0]  bte;
  logic [2:0]  cti;
  int          tsel;
  int          checks = 0;
  int          failures = 0;

  logic        ack_a, err_a, rty_a, ack_b, err_b, rty_b, ack_c, err_c, rty_c;
  logic [31:0] dat_a, dat_c;
  logic [63:0] dat_b;
  logic        ack_m, err_m;
  logic [63:0] dat_m;

  always #5 clk = ~clk;

  ram_wb_b3_gen u_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat[31:0]),
    .wb_sel_i(sel[3:0]), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc & (tsel == 0)), .wb_stb_i(stb & (tsel == 0)),
    .wb_ack_o(ack_a), .wb_err_o(err_a), .wb_rty_o(rty_a), .wb_dat_o(dat_a));

  ram_wb_b3_gen #(.dw(64), .mem_size_bytes(32'h0000_0100)) u_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc & (tsel == 1)), .wb_stb_i(stb & (tsel == 1)),
    .wb_ack_o(ack_b), .wb_err_o(err_b), .wb_rty_o(rty_b), .wb_dat_o(dat_b));

  ram_wb_b3_gen #(.read_only(1'b1), .mem_size_bytes(32'h0000_0100)) u_c (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat[31:0]),
    .wb_sel_i(sel[3:0]), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc & (tsel == 2)), .wb_stb_i(stb & (tsel == 2)),
    .wb_ack_o(ack_c), .wb_err_o(err_c), .wb_rty_o(rty_c), .wb_dat_o(dat_c));

  always_comb begin
    case (tsel)
      0:       begin ack_m = ack_a; err_m = err_a; dat_m = {32'd0, dat_a}; end
      1:       begin ack_m = ack_b; err_m = err_b; dat_m = dat_b; end
      default: begin ack_m = ack_c; err_m = err_c; dat_m = {32'd0, dat_c}; end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Classic single access; entered and left just after a rising edge.
  task automatic classic(input string tag, input logic [31:0] a, input logic w,
                         input logic [63:0] d, input logic [7:0] s, input logic exp_err,
                         input logic chk_dat, input logic [63:0] exp_d);
    adr = a; we = w; dat = d; sel = s; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check({tag, ".lat"}, 64'({ack_m, err_m}), 64'd0);
    @(negedge clk);
    check({tag, ".ack"}, 64'(ack_m), 64'(!exp_err));
    check({tag, ".err"}, 64'(err_m), 64'(exp_err));
    if (chk_dat) check({tag, ".dat"}, dat_m, exp_d);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check({tag, ".end"}, 64'({ack_m, err_m}), 64'd0);
    @(posedge clk); #1;
  endtask

  // Check one bus cycle of a burst, then advance to just after the next rising edge.
  task automatic beat(input string tag, input logic exp_ack, input logic exp_err,
                      input logic chk_dat, input logic [63:0] exp_d);
    @(negedge clk);
    check({tag, ".ack"}, 64'(ack_m), 64'(exp_ack));
    check({tag, ".err"}, 64'(err_m), 64'(exp_err));
    if (chk_dat) check({tag, ".dat"}, dat_m, exp_d);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat = 64'd0;
    sel = 8'd0; bte = 2'b00; cti = 3'b000; tsel = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.a", {29'd0, ack_a, err_a, rty_a, dat_a}, 64'd0);
    check("rst.b", 64'({ack_b, err_b, rty_b}), 64'd0);
    check("rst.b.dat", dat_b, 64'd0);
    check("rst.c", {29'd0, ack_c, err_c, rty_c, dat_c}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Classic write/read, 32-bit.
    tsel = 0;
    classic("cw10", 32'h10, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0, 1'b0, 64'd0);
    classic("cr10", 32'h10, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'hDEAD_BEEF);
    classic("cw14", 32'h14, 1'b1, 64'h55, 8'h0F, 1'b0, 1'b0, 64'd0);
    classic("cw18", 32'h18, 1'b1, 64'h66, 8'h0F, 1'b0, 1'b0, 64'd0);
    classic("cw1c", 32'h1C, 1'b1, 64'h77, 8'h0F, 1'b0, 1'b0, 64'd0);

    // Wrap-4 read burst from 0x18: words 6,7,4,5.
    adr = 32'h18; cti = 3'b010; bte = 2'b01; we = 1'b0; sel = 8'h0F; cyc = 1'b1; stb = 1'b1;
    beat("w4.lat", 1'b0, 1'b0, 1'b0, 64'd0);
    beat("w4.b0", 1'b1, 1'b0, 1'b1, 64'h66);
    adr = 32'h1C;
    beat("w4.b1", 1'b1, 1'b0, 1'b1, 64'h77);
    adr = 32'h10;
    beat("w4.b2", 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF);
    adr = 32'h14; cti = 3'b111;
    beat("w4.b3", 1'b1, 1'b0, 1'b1, 64'h55);
    cyc = 1'b0; stb = 1'b0;
    classic("w4.idle", 32'h18, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'h66);

    // Constant-address burst with write-to-read bypass.
    adr = 32'h40; cti = 3'b001; bte = 2'b00; we = 1'b1; dat = 64'hA; sel = 8'h0F;
    cyc = 1'b1; stb = 1'b1;
    beat("cb.lat", 1'b0, 1'b0, 1'b0, 64'd0);
    beat("cb.b0", 1'b1, 1'b0, 1'b0, 64'd0);
    dat = 64'hB;
    beat("cb.b1", 1'b1, 1'b0, 1'b1, 64'hA);
    we = 1'b0; cti = 3'b111;
    beat("cb.b2", 1'b1, 1'b0, 1'b1, 64'hB);
    cyc = 1'b0; stb = 1'b0;
    classic("cb.rd", 32'h40, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'hB);

    // Out-of-range address: error pulse, memory unchanged.
    classic("oor.pre", 32'h0, 1'b1, 64'h0102_0304, 8'h0F, 1'b0, 1'b0, 64'd0);
    classic("oor", 32'h0010_0000, 1'b1, 64'hFFFF_FFFF, 8'h0F, 1'b1, 1'b0, 64'd0);
    classic("oor.rd", 32'h0, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'h0102_0304);

    // Burst that skips a word: error instead of ack, skipped word untouched.
    classic("sk.pre", 32'h68, 1'b1, 64'h5678, 8'h0F, 1'b0, 1'b0, 64'd0);
    adr = 32'h60; cti = 3'b010; bte = 2'b00; we = 1'b1; dat = 64'hCAFE; sel = 8'h0F;
    cyc = 1'b1; stb = 1'b1;
    beat("sk.lat", 1'b0, 1'b0, 1'b0, 64'd0);
    beat("sk.b0", 1'b1, 1'b0, 1'b0, 64'd0);
    adr = 32'h68; dat = 64'hBAD;
    beat("sk.b1", 1'b0, 1'b0, 1'b0, 64'd0);
    beat("sk.e", 1'b0, 1'b1, 1'b0, 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    classic("sk.rd68", 32'h68, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'h5678);
    classic("sk.rd60", 32'h60, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'hCAFE);

    // Async reset during a linear write burst after two beats.
    adr = 32'h80; cti = 3'b010; bte = 2'b00; we = 1'b1; dat = 64'h11; sel = 8'h0F;
    cyc = 1'b1; stb = 1'b1;
    beat("rs.lat", 1'b0, 1'b0, 1'b0, 64'd0);
    beat("rs.b0", 1'b1, 1'b0, 1'b0, 64'd0);
    adr = 32'h84; dat = 64'h22;
    beat("rs.b1", 1'b1, 1'b0, 1'b0, 64'd0);
    adr = 32'h88; dat = 64'h33;
    @(negedge clk);
    check("rs.pre", 64'(ack_m), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rs.ack", 64'({ack_m, err_m}), 64'd0);
    check("rs.dat", dat_m, 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    classic("rs.rd80", 32'h80, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'h11);
    classic("rs.rd84", 32'h84, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b1, 64'h22);

    // 64-bit byte enables and the end-of-memory boundary.
    tsel = 1;
    classic("be.fill", 32'h0, 1'b1, 64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0, 64'd0);
    classic("be.fill2", 32'h0, 1'b1, 64'h1111_2222_3333_4444, 8'hF0, 1'b0, 1'b0, 64'd0);
    classic("be.fill3", 32'h0, 1'b1, 64'h5555_6666_7777_8888, 8'h0F, 1'b0, 1'b0, 64'd0);
    classic("be.sel", 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 1'b0, 1'b0, 64'd0);
    classic("be.rd", 32'h0, 1'b0, 64'd0, 8'hFF, 1'b0, 1'b1, 64'hFF11_2222_7777_88FF);
    classic("b64.w", 32'hF8, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0, 64'd0);
    classic("b64.r", 32'hF8, 1'b0, 64'd0, 8'hFF, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
    classic("b64.oor", 32'h100, 1'b0, 64'd0, 8'hFF, 1'b1, 1'b0, 64'd0);

    // Read-only instance: writes error, reads ack.
    tsel = 2;
    classic("ro.w", 32'h0, 1'b1, 64'h1234, 8'h0F, 1'b1, 1'b0, 64'd0);
    classic("ro.r", 32'h0, 1'b0, 64'd0, 8'h0F, 1'b0, 1'b0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
